multicycle_ctrl: RTL
====================

Name: multicycle_ctrl

Overview:
Multi-cycle control unit for the KGP-RISC 32-bit datapath. It sequences each instruction through FETCH, DECODE, EXEC, MEM and WB. It drives the immediate extender's sign/zero select, ALU operand/op selects, register-file write and PC update. It handshakes with instruction and data memory and traps on illegal opcodes or memory timeouts.

Parameters:
MEM_TIMEOUT, 16, number of cycles a memory request may wait for ack before trapping (legal range 1..255)
CNT_W, 8, width of the timeout counter

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset
run  input  1  enable; sampled only when a new fetch would begin
ir  input  32  instruction register contents; opcode = ir[31:26], imm = ir[15:0]
br_cond  input  1  ALU branch-condition flag, valid in EXEC
imem_ack  input  1  instruction memory done; ir valid next cycle
dmem_ack  input  1  data memory done
imem_req  output  1  instruction fetch request
ir_we  output  1  latch fetched instruction into ir
dmem_req  output  1  data memory request
dmem_we  output  1  1 = store, 0 = load (valid with dmem_req)
ext_sel  output  1  immediate extender mode: 1 = sign-extend imm[15:0], 0 = zero-extend
alu_src_imm  output  1  ALU operand B = extended immediate
alu_op  output  3  ALU function code (package constants)
reg_we  output  1  register-file write enable
wb_sel  output  1  0 = ALU result, 1 = load data
pc_we  output  1  PC write enable
pc_src  output  2  00 pc+4, 01 pc+sext(imm), 10 jump target
halted  output  1  HALT executed
illegal  output  1  trap taken (illegal opcode or timeout)
state_o  output  3  current state, debug

Behaviour:
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT, TRAP. Encoding is fixed in the package.
- Reset (rst=0, asynchronous): state=IDLE, timeout counter=0, latched opcode=0. All outputs 0, except pc_src=00 and alu_op=ADD.
- Outputs are Moore functions of state and the opcode latched in DECODE. They are glitch-free relative to clk.
- Opcodes:
  - 000000 ALU-R
  - 000001 ALU-imm arithmetic (sign-extend)
  - 000110 ALU-imm logical (zero-extend)
  - 000010 LOAD
  - 000011 STORE
  - 000100 BRANCH
  - 000101 JUMP
  - 111111 HALT
  - all others are illegal.
- IDLE: if run=1, go to FETCH next cycle.
- FETCH: imem_req=1. On the cycle imem_ack=1: ir_we=1 and go to DECODE. The request drops the following cycle.
- DECODE (1 cycle): latch opcode. ext_sel is valid from this cycle until the instruction completes. Next-state depends on opcode:
  - illegal opcode -> TRAP
  - HALT -> HALT
  - all others -> EXEC
- EXEC (1 cycle):
  - alu_src_imm=1 for ALU-imm, LOAD and STORE. alu_op comes from the opcode; ADD is used for LOAD/STORE.
  - ALU-* -> WB.
  - LOAD/STORE -> MEM.
  - BRANCH: pc_we=1; pc_src=01 if br_cond=1, else 00. Then go to FETCH (or IDLE if run=0).
  - JUMP: pc_we=1, pc_src=10, then FETCH/IDLE.
- MEM: dmem_req=1; dmem_we=1 for STORE. On dmem_ack:
  - LOAD -> WB.
  - STORE: pc_we=1, pc_src=00, then FETCH/IDLE.
- WB (1 cycle): reg_we=1; wb_sel=1 for LOAD; pc_we=1, pc_src=00. Then FETCH if run=1, else IDLE.
- Minimum latencies (ack on first request cycle):
  - ALU 4 cycles
  - LOAD 5 cycles
  - STORE 4 cycles
  - BRANCH/JUMP 3 cycles
- Timeout counter:
  - Clears on entry to FETCH or MEM.
  - Increments each cycle the request is held without ack.
  - Reaching MEM_TIMEOUT with no ack -> TRAP.
  - Ack on the same cycle the count reaches MEM_TIMEOUT wins: no trap.
- Acks arriving while no request is active are ignored.
- HALT and TRAP are absorbing. halted=1 / illegal=1 is held until reset. No PC or register writes occur in these states.
- pc_we is never asserted in HALT or TRAP. It is asserted exactly once per completed instruction.
- run=0 mid-instruction does not abort; it only takes effect at instruction completion.
- Reset asserted mid-MEM drops dmem_req asynchronously.

Decomposition:
- Package kgp_ctrl_pkg holds:
  - opcode constants
  - state enumeration (3-bit)
  - alu_op codes: ADD, SUB, AND, OR, XOR, SLT, SHL, SHR
  - pc_src codes
- One sub-module, mem_timeout_counter, takes clear/enable/limit and outputs expired. It is shared by the FETCH and MEM paths.

Test Plan:
- ALU-imm arithmetic, ir=0x0420FFFF, imem_ack immediate -> ext_sel=1 from DECODE; reg_we pulse in cycle 4; pc_we once with pc_src=00.
- ALU-imm logical, opcode 000110, imm 0x8000 -> ext_sel=0 throughout; alu_src_imm=1 in EXEC.
- LOAD with dmem_ack delayed 3 cycles -> dmem_req high 4 cycles, dmem_we=0; WB has wb_sel=1, reg_we=1; total 8 cycles.
- BRANCH with br_cond=1 then another with br_cond=0 -> pc_src=01 vs 00 in EXEC; no reg_we; 3 cycles each.
- Illegal opcode 0x2A, and separately imem_ack withheld 16 cycles (MEM_TIMEOUT=16) -> TRAP, illegal=1 held, no further imem_req; ack at cycle 16 exactly -> no trap.
- HALT opcode, then rst pulsed low mid-MEM of a STORE -> halted=1 sticky; asynchronous return to IDLE with all outputs 0 during reset.

Source files
------------

// File: rtl/multicycle_ctrl_pkg.sv
// kgp_ctrl_pkg: shared definitions for the KGP-RISC multi-cycle controller.
// Holds the opcode map, the fixed 3-bit state encoding, ALU function codes,
// PC source codes and small opcode-classification helpers used by the FSM.
package kgp_ctrl_pkg;

   // Opcodes (ir[31:26])
   localparam logic [5:0] OP_ALU_R     = 6'b000000;
   localparam logic [5:0] OP_ALUI_ARITH = 6'b000001;
   localparam logic [5:0] OP_LOAD      = 6'b000010;
   localparam logic [5:0] OP_STORE     = 6'b000011;
   localparam logic [5:0] OP_BRANCH    = 6'b000100;
   localparam logic [5:0] OP_JUMP      = 6'b000101;
   localparam logic [5:0] OP_ALUI_LOGIC = 6'b000110;
   localparam logic [5:0] OP_HALT      = 6'b111111;

   // Controller states, encoding is part of the debug interface (state_o)
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_DECODE = 3'd2,
      ST_EXEC   = 3'd3,
      ST_MEM    = 3'd4,
      ST_WB     = 3'd5,
      ST_HALT   = 3'd6,
      ST_TRAP   = 3'd7
   } state_t;

   // ALU function codes
   typedef enum logic [2:0] {
      ALU_ADD = 3'd0,
      ALU_SUB = 3'd1,
      ALU_AND = 3'd2,
      ALU_OR  = 3'd3,
      ALU_XOR = 3'd4,
      ALU_SLT = 3'd5,
      ALU_SHL = 3'd6,
      ALU_SHR = 3'd7
   } alu_op_t;

   // PC source select codes
   localparam logic [1:0] PC_SEQ  = 2'b00;  // pc + 4
   localparam logic [1:0] PC_BR   = 2'b01;  // pc + sext(imm)
   localparam logic [1:0] PC_JUMP = 2'b10;  // jump target

   // True for every opcode the controller knows how to sequence.
   function automatic logic is_legal(input logic [5:0] op);
      logic ok;
      case (op)
         OP_ALU_R, OP_ALUI_ARITH, OP_ALUI_LOGIC, OP_LOAD,
         OP_STORE, OP_BRANCH, OP_JUMP, OP_HALT: ok = 1'b1;
         default:                               ok = 1'b0;
      endcase
      return ok;
   endfunction

   // Immediate extender mode: offsets and arithmetic immediates are signed,
   // logical immediates (and ops without an immediate) are zero-extended.
   function automatic logic sext_of(input logic [5:0] op);
      logic s;
      case (op)
         OP_ALUI_ARITH, OP_LOAD, OP_STORE, OP_BRANCH: s = 1'b1;
         default:                                     s = 1'b0;
      endcase
      return s;
   endfunction

   // Operand B comes from the extended immediate.
   function automatic logic imm_src_of(input logic [5:0] op);
      logic s;
      case (op)
         OP_ALUI_ARITH, OP_ALUI_LOGIC, OP_LOAD, OP_STORE: s = 1'b1;
         default:                                         s = 1'b0;
      endcase
      return s;
   endfunction

   // Opcode-only ALU decode: branches compare by subtraction, logical
   // immediates OR, address and arithmetic forms add.
   function automatic logic [2:0] alu_op_of(input logic [5:0] op);
      logic [2:0] a;
      case (op)
         OP_BRANCH:     a = ALU_SUB;
         OP_ALUI_LOGIC: a = ALU_OR;
         default:       a = ALU_ADD;
      endcase
      return a;
   endfunction

endpackage

// File: rtl/multicycle_ctrl_mem_timeout_counter.sv
// mem_timeout_counter: counts cycles a memory request waits for its ack.
// Ports: clk/rst (async active-low), clear (restart at 0), enable (request
// held without ack this cycle), limit (allowed wait cycles), expired (this
// waiting cycle is the last one permitted -> caller traps).
module mem_timeout_counter #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             enable,
   input  logic [CNT_W-1:0] limit,
   output logic             expired
);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   // Next count: clear wins, saturate at all-ones.
   always_comb begin
      count_d = count_q;
      if (clear) begin
         count_d = {CNT_W{1'b0}};
      end else if (enable && (count_q != {CNT_W{1'b1}})) begin
         count_d = count_q + CNT_W'(1'b1);
      end else begin
         count_d = count_q;
      end
   end

   // Count register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count_q <= {CNT_W{1'b0}};
      end else begin
         count_q <= count_d;
      end
   end

   // A waiting cycle whose increment would reach the limit is the last one;
   // an ack in that cycle deasserts enable and therefore wins.
   assign expired = enable && (count_q == (limit - CNT_W'(1'b1)));

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multi-cycle control unit for the KGP-RISC datapath.
// Sequences FETCH/DECODE/EXEC/MEM/WB, traps on illegal opcodes and memory
// timeouts, halts on HALT.
// Ports: clk, rst (async active-low), run, ir, br_cond, imem_ack, dmem_ack in;
// imem_req, ir_we, dmem_req, dmem_we, ext_sel, alu_src_imm, alu_op, reg_we,
// wb_sel, pc_we, pc_src, halted, illegal, state_o out.
module multicycle_ctrl
   import kgp_ctrl_pkg::*;
#(
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        run,
   input  logic [31:0] ir,
   input  logic        br_cond,
   input  logic        imem_ack,
   input  logic        dmem_ack,
   output logic        imem_req,
   output logic        ir_we,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic        ext_sel,
   output logic        alu_src_imm,
   output logic [2:0]  alu_op,
   output logic        reg_we,
   output logic        wb_sel,
   output logic        pc_we,
   output logic [1:0]  pc_src,
   output logic        halted,
   output logic        illegal,
   output logic [2:0]  state_o
);

   localparam logic [CNT_W-1:0] TMO_LIMIT = CNT_W'(MEM_TIMEOUT);

   state_t      state_q, state_d;
   logic [5:0]  op_q, op_d;
   logic        imem_req_q, imem_req_d;
   logic        dmem_req_q, dmem_req_d;
   logic        dmem_we_q, dmem_we_d;
   logic        ext_sel_q, ext_sel_d;
   logic        alu_src_imm_q, alu_src_imm_d;
   logic [2:0]  alu_op_q, alu_op_d;
   logic        reg_we_q, reg_we_d;
   logic        wb_sel_q, wb_sel_d;
   logic        halted_q, halted_d;
   logic        illegal_q, illegal_d;

   logic        tmo_en_s;
   logic        tmo_clear_s;
   logic        tmo_expired_s;
   logic        ir_unused_s;

   // Only the opcode field is decoded here; the rest belongs to the datapath.
   assign ir_unused_s = ^ir[25:0];

   // Request held this cycle with no ack.
   assign tmo_en_s = ((state_q == ST_FETCH) && !imem_ack) ||
                     ((state_q == ST_MEM)   && !dmem_ack);

   // Restart the wait count on every entry into a request state (MEM can go
   // straight back to FETCH, so "not in a request state" is not enough).
   assign tmo_clear_s = ((state_d == ST_FETCH) || (state_d == ST_MEM)) &&
                        (state_d != state_q);

   mem_timeout_counter #(
      .CNT_W (CNT_W)
   ) u_tmo (
      .clk     (clk),
      .rst     (rst),
      .clear   (tmo_clear_s),
      .enable  (tmo_en_s),
      .limit   (TMO_LIMIT),
      .expired (tmo_expired_s)
   );

   // Next-state and opcode latch.
   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      case (state_q)
         ST_IDLE: begin
            if (run) state_d = ST_FETCH;
            else     state_d = ST_IDLE;
         end
         ST_FETCH: begin
            if (imem_ack)           state_d = ST_FETCH == ST_FETCH ? ST_DECODE : ST_DECODE;
            else if (tmo_expired_s) state_d = ST_TRAP;
            else                    state_d = ST_FETCH;
         end
         ST_DECODE: begin
            op_d = ir[31:26];
            if (!is_legal(ir[31:26]))       state_d = ST_TRAP;
            else if (ir[31:26] == OP_HALT)  state_d = ST_HALT;
            else                            state_d = ST_EXEC;
         end
         ST_EXEC: begin
            case (op_q)
               OP_ALU_R, OP_ALUI_ARITH, OP_ALUI_LOGIC: state_d = ST_WB;
               OP_LOAD, OP_STORE:                      state_d = ST_MEM;
               OP_BRANCH, OP_JUMP: begin
                  if (run) state_d = ST_FETCH;
                  else     state_d = ST_IDLE;
               end
               default: state_d = ST_TRAP;
            endcase
         end
         ST_MEM: begin
            if (dmem_ack) begin
               if (op_q == OP_LOAD) state_d = ST_WB;
               else if (run)        state_d = ST_FETCH;
               else                 state_d = ST_IDLE;
            end else if (tmo_expired_s) begin
               state_d = ST_TRAP;
            end else begin
               state_d = ST_MEM;
            end
         end
         ST_WB: begin
            if (run) state_d = ST_FETCH;
            else     state_d = ST_IDLE;
         end
         ST_HALT: state_d = ST_HALT;
         ST_TRAP: state_d = ST_TRAP;
         default: state_d = ST_IDLE;
      endcase
   end

   // Moore outputs for the next cycle, computed from the next state so they
   // can be registered and still line up with the state they belong to.
   always_comb begin
      imem_req_d = (state_d == ST_FETCH);
      dmem_req_d = (state_d == ST_MEM);
      dmem_we_d  = (state_d == ST_MEM) && (op_d == OP_STORE);
      reg_we_d   = (state_d == ST_WB);
      wb_sel_d   = (state_d == ST_WB) && (op_d == OP_LOAD);
      halted_d   = (state_d == ST_HALT);
      illegal_d  = (state_d == ST_TRAP);
      if (state_d == ST_EXEC) begin
         alu_op_d      = alu_op_of(op_d);
         alu_src_imm_d = imm_src_of(op_d);
      end else begin
         alu_op_d      = ALU_ADD;
         alu_src_imm_d = 1'b0;
      end
      if ((state_d == ST_EXEC) || (state_d == ST_MEM) || (state_d == ST_WB)) begin
         ext_sel_d = sext_of(op_d);
      end else begin
         ext_sel_d = 1'b0;
      end
   end

   // FSM state, latched opcode and registered outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= ST_IDLE;
         op_q          <= 6'b000000;
         imem_req_q    <= 1'b0;
         dmem_req_q    <= 1'b0;
         dmem_we_q     <= 1'b0;
         ext_sel_q     <= 1'b0;
         alu_src_imm_q <= 1'b0;
         alu_op_q      <= ALU_ADD;
         reg_we_q      <= 1'b0;
         wb_sel_q      <= 1'b0;
         halted_q      <= 1'b0;
         illegal_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         op_q          <= op_d;
         imem_req_q    <= imem_req_d;
         dmem_req_q    <= dmem_req_d;
         dmem_we_q     <= dmem_we_d;
         ext_sel_q     <= ext_sel_d;
         alu_src_imm_q <= alu_src_imm_d;
         alu_op_q      <= alu_op_d;
         reg_we_q      <= reg_we_d;
         wb_sel_q      <= wb_sel_d;
         halted_q      <= halted_d;
         illegal_q     <= illegal_d;
      end
   end

   // Strobes qualified by same-cycle inputs (ack, br_cond) off registered state.
   always_comb begin
      ir_we  = 1'b0;
      pc_we  = 1'b0;
      pc_src = PC_SEQ;
      case (state_q)
         ST_FETCH: ir_we = imem_ack;
         ST_EXEC: begin
            if (op_q == OP_BRANCH) begin
               pc_we  = 1'b1;
               pc_src = br_cond ? PC_BR : PC_SEQ;
            end else if (op_q == OP_JUMP) begin
               pc_we  = 1'b1;
               pc_src = PC_JUMP;
            end else begin
               pc_we  = 1'b0;
               pc_src = PC_SEQ;
            end
         end
         ST_MEM: pc_we = dmem_ack && (op_q == OP_STORE);
         ST_WB:  pc_we = 1'b1;
         default: begin
            ir_we  = 1'b0;
            pc_we  = 1'b0;
            pc_src = PC_SEQ;
         end
      endcase
   end

   // The opcode is only latched at the end of DECODE, so the extender mode
   // for the DECODE cycle itself is taken straight from ir.
   assign ext_sel     = (state_q == ST_DECODE) ? sext_of(ir[31:26]) : ext_sel_q;
   assign imem_req    = imem_req_q;
   assign dmem_req    = dmem_req_q;
   assign dmem_we     = dmem_we_q;
   assign alu_src_imm = alu_src_imm_q;
   assign alu_op      = alu_op_q;
   assign reg_we      = reg_we_q;
   assign wb_sel      = wb_sel_q;
   assign halted      = halted_q;
   assign illegal     = illegal_q;
   assign state_o     = state_q;

endmodule
